// File: rtl/crp16_pkg.sv
// crp16_pkg
//   Shared CRP16 definitions used by the program loader.
//   - loader_state_e : 3-bit loader FSM state encoding
//   - LOADER_BASE_ADDR : default RAM word address of the first loaded word
//   - loader_busy() : true for the states in which a load is in progress
package crp16_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_HDR_HI = 3'd1,
        ST_HDR_LO = 3'd2,
        ST_DAT_HI = 3'd3,
        ST_DAT_LO = 3'd4,
        ST_WRITE  = 3'd5,
        ST_DONE   = 3'd6
    } loader_state_e;

    localparam logic [15:0] LOADER_BASE_ADDR = 16'h0000;

    function automatic logic loader_busy(input loader_state_e s);
        return (s == ST_HDR_HI) || (s == ST_HDR_LO) || (s == ST_DAT_HI) ||
               (s == ST_DAT_LO) || (s == ST_WRITE);
    endfunction

endpackage

// File: rtl/register.sv
// register
//   Generic enabled register with synchronous active-low clear.
//   Ports:
//     clk_i  : clock, rising edge
//     rst_ni : synchronous active-low reset, clears q_o to zero
//     en_i   : load enable
//     d_i    : next value, loaded when en_i is high
//     q_o    : current value
module register #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            q_o <= '0;
        end else if (en_i) begin
            q_o <= d_i;
        end
    end

endmodule

// File: rtl/crp16_prog_loader.sv
// crp16_prog_loader
//   Loads a program image into the CRP16 unified RAM from a byte stream and
//   then releases the CPU. Sits between datapath port B and RAM port B:
//   while loading the loader owns RAM port B and the CPU is held; once the
//   load is complete the datapath port-B signals pass straight through.
//   Frame: 16-bit word count N, then N 16-bit words, all high byte first.
//   Ports:
//     clock, reset          : clock; synchronous active-low reset
//     start                 : request a (re)load, honoured in IDLE and DONE
//     in_data/in_valid/in_ready : byte stream with valid/ready handshake
//     cpu_hold              : 1 while the datapath must stay held
//     busy                  : 1 while a load is in progress
//     words_loaded          : words written so far in the current load
//     dp_address_b/dp_data_b/dp_wren_b : datapath port-B request
//     address_b/data_b/wren_b          : RAM port-B request
module crp16_prog_loader
    import crp16_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR = LOADER_BASE_ADDR,
    parameter bit          AUTO_LOAD = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        cpu_hold,
    output logic        busy,
    output logic [15:0] words_loaded,
    input  logic [15:0] dp_address_b,
    input  logic [15:0] dp_data_b,
    input  logic        dp_wren_b,
    output logic [15:0] address_b,
    output logic [15:0] data_b,
    output logic        wren_b
);

    loader_state_e state_q, state_d;

    // Set by reset when AUTO_LOAD is enabled; consumed by the first edge
    // with reset released, which is the edge that leaves IDLE.
    logic auto_q;

    logic        cnt_en,  word_en,  wl_en;
    logic [15:0] cnt_d,   word_d,   wl_d;
    logic [15:0] cnt_q,   word_q,   wl_q;
    logic [15:0] wl_inc;
    logic [15:0] load_addr;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            auto_q  <= AUTO_LOAD;
        end else begin
            state_q <= state_d;
            auto_q  <= 1'b0;
        end
    end

    register #(.WIDTH(16)) u_cnt_reg (
        .clk_i  (clock),
        .rst_ni (reset),
        .en_i   (cnt_en),
        .d_i    (cnt_d),
        .q_o    (cnt_q)
    );

    register #(.WIDTH(16)) u_word_reg (
        .clk_i  (clock),
        .rst_ni (reset),
        .en_i   (word_en),
        .d_i    (word_d),
        .q_o    (word_q)
    );

    register #(.WIDTH(16)) u_words_loaded_reg (
        .clk_i  (clock),
        .rst_ni (reset),
        .en_i   (wl_en),
        .d_i    (wl_d),
        .q_o    (wl_q)
    );

    assign wl_inc = wl_q + 16'd1;

    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        cnt_en   = 1'b0;
        cnt_d    = cnt_q;
        word_en  = 1'b0;
        word_d   = word_q;
        wl_en    = 1'b0;
        wl_d     = wl_q;

        case (state_q)
            ST_IDLE: begin
                // in_ready stays low here, so a byte offered together with
                // start is not consumed on this edge.
                if (start || auto_q) begin
                    state_d = ST_HDR_HI;
                    wl_en   = 1'b1;
                    wl_d    = '0;
                end
            end
            ST_HDR_HI: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    cnt_en  = 1'b1;
                    cnt_d   = {in_data, cnt_q[7:0]};
                    state_d = ST_HDR_LO;
                end
            end
            ST_HDR_LO: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    cnt_en  = 1'b1;
                    cnt_d   = {cnt_q[15:8], in_data};
                    // An empty image completes without any write.
                    state_d = ({cnt_q[15:8], in_data} == 16'h0000) ? ST_DONE : ST_DAT_HI;
                end
            end
            ST_DAT_HI: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    word_en = 1'b1;
                    word_d  = {in_data, word_q[7:0]};
                    state_d = ST_DAT_LO;
                end
            end
            ST_DAT_LO: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    word_en = 1'b1;
                    word_d  = {word_q[15:8], in_data};
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                wl_en   = 1'b1;
                wl_d    = wl_inc;
                state_d = (wl_inc == cnt_q) ? ST_DONE : ST_DAT_HI;
            end
            ST_DONE: begin
                if (start) begin
                    state_d = ST_HDR_HI;
                    wl_en   = 1'b1;
                    wl_d    = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign load_addr    = BASE_ADDR + wl_q;
    assign busy         = loader_busy(state_q);
    assign cpu_hold     = (state_q != ST_DONE);
    assign words_loaded = wl_q;

    // Port-B ownership. The loader write is qualified with reset so that a
    // reset arriving during WRITE aborts without committing that word.
    always_comb begin
        if (state_q == ST_DONE) begin
            address_b = dp_address_b;
            data_b    = dp_data_b;
            wren_b    = dp_wren_b;
        end else begin
            address_b = load_addr;
            data_b    = word_q;
            wren_b    = (state_q == ST_WRITE) && reset;
        end
    end

endmodule
